// File: rtl/mo_pkg.sv
// rtl/mo_pkg.sv - shared types and constants for the motion-object line scheduler
// Contents: FSM state enum, descriptor field widths/positions, word indices,
// default table geometry and the VRAM word-address helper.
package mo_pkg;

   localparam logic [13:0] MO_BASE_DEF      = 14'h3800;
   localparam int          NUM_SLOTS_DEF    = 64;
   localparam int          MAX_PER_LINE_DEF = 16;

   localparam int YPOS_W  = 9;
   localparam int XPOS_W  = 9;
   localparam int CODE_W  = 16;
   localparam int PAL_W   = 4;
   localparam int LINK_W  = 6;
   localparam int YSIZE_W = 3;
   localparam int ROW_W   = 6;

   // Bit positions inside word0 / word2
   localparam int YSIZE_LSB = 13;
   localparam int HFLIP_BIT = 12;
   localparam int PAL_LSB   = 12;

   localparam logic [1:0] W_Y    = 2'd0;
   localparam logic [1:0] W_CODE = 2'd1;
   localparam logic [1:0] W_X    = 2'd2;
   localparam logic [1:0] W_LINK = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_RD2,
      ST_RD3,
      ST_CHECK,
      ST_ISSUE,
      ST_NEXT
   } state_t;

   // Word w of slot s lives at base + w*64 + s
   function automatic logic [13:0] word_addr(input logic [13:0] base,
                                             input logic [1:0] w,
                                             input logic [LINK_W-1:0] slot);
      return base + {6'd0, w, 6'd0} + {8'd0, slot};
   endfunction

endpackage

// File: rtl/mo_vmatch.sv
// rtl/mo_vmatch.sv - combinational vertical intersection test for one object
// Ports: vline (line being built), ypos/ysize (object) -> hit, row within object.
module mo_vmatch
   import mo_pkg::*;
(
   input  logic [YPOS_W-1:0]  vline,
   input  logic [YPOS_W-1:0]  ypos,
   input  logic [YSIZE_W-1:0] ysize,
   output logic               hit,
   output logic [ROW_W-1:0]   row
);

   logic [YPOS_W-1:0] diff;
   logic [YPOS_W-1:0] limit;

   // 9-bit subtraction wraps, so objects straddling line 511/0 still match
   assign diff  = vline - ypos;
   assign limit = ({6'd0, ysize} + 9'd1) << 3;
   assign hit   = (diff < limit);
   assign row   = diff[ROW_W-1:0];

endmodule

// File: rtl/mo_line_scheduler.sv
// rtl/mo_line_scheduler.sv - per-scanline MO list walker issuing draw commands
// Ports: hblank_start/vcount start a line; vram_req/addr/gnt/rdata read the MO
// table; draw_* is a valid/ready command to the line-buffer writer; buf_sel is
// the buffer being written; busy/overflow/overrun report walk status.
module mo_line_scheduler
   import mo_pkg::*;
#(
   parameter logic [13:0] MO_BASE      = MO_BASE_DEF,
   parameter int          NUM_SLOTS    = NUM_SLOTS_DEF,
   parameter int          MAX_PER_LINE = MAX_PER_LINE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               hblank_start,
   input  logic [8:0]         vcount,
   output logic               vram_req,
   output logic [13:0]        vram_addr,
   input  logic               vram_gnt,
   input  logic [15:0]        vram_rdata,
   output logic               draw_valid,
   input  logic               draw_ready,
   output logic [CODE_W-1:0]  draw_code,
   output logic [ROW_W-1:0]   draw_row,
   output logic [XPOS_W-1:0]  draw_xpos,
   output logic [PAL_W-1:0]   draw_pal,
   output logic               draw_hflip,
   output logic               buf_sel,
   output logic               busy,
   output logic               overflow,
   output logic               overrun
);

   localparam int LC_W = $clog2(NUM_SLOTS + 1);
   localparam int HC_W = $clog2(MAX_PER_LINE + 1);

   state_t             state;
   logic               pending;      // granted, data arrives this cycle
   logic [YPOS_W-1:0]  vline;
   logic [LINK_W-1:0]  slot;
   logic [LINK_W-1:0]  link_q;
   logic [LC_W-1:0]    link_cnt;
   logic [HC_W-1:0]    hit_cnt;
   logic [YPOS_W-1:0]  ypos_q;
   logic [YSIZE_W-1:0] ysize_q;
   logic               hflip_q;
   logic [CODE_W-1:0]  code_q;
   logic [XPOS_W-1:0]  xpos_q;
   logic [PAL_W-1:0]   pal_q;

   logic [YPOS_W-1:0]  vm_ypos;
   logic [YSIZE_W-1:0] vm_ysize;
   logic               vm_hit;
   logic [ROW_W-1:0]   vm_row;
   logic [LC_W-1:0]    link_cnt_inc;
   logic [HC_W-1:0]    hit_cnt_inc;
   logic               unused_rdata;

   // While word0 is landing, test the raw read data so RD1/RD2 can be skipped
   assign vm_ypos  = (state == ST_RD0) ? vram_rdata[YPOS_W-1:0] : ypos_q;
   assign vm_ysize = (state == ST_RD0) ? vram_rdata[YSIZE_LSB +: YSIZE_W] : ysize_q;

   mo_vmatch u_vmatch (
      .vline (vline),
      .ypos  (vm_ypos),
      .ysize (vm_ysize),
      .hit   (vm_hit),
      .row   (vm_row)
   );

   assign link_cnt_inc = link_cnt + 1'b1;
   assign hit_cnt_inc  = hit_cnt + 1'b1;
   assign busy         = (state != ST_IDLE);
   assign overrun      = hblank_start & busy;
   assign unused_rdata = ^vram_rdata[11:9];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         pending    <= 1'b0;
         vline      <= '0;
         slot       <= '0;
         link_q     <= '0;
         link_cnt   <= '0;
         hit_cnt    <= '0;
         ypos_q     <= '0;
         ysize_q    <= '0;
         hflip_q    <= 1'b0;
         code_q     <= '0;
         xpos_q     <= '0;
         pal_q      <= '0;
         vram_req   <= 1'b0;
         vram_addr  <= '0;
         draw_valid <= 1'b0;
         draw_code  <= '0;
         draw_row   <= '0;
         draw_xpos  <= '0;
         draw_pal   <= '0;
         draw_hflip <= 1'b0;
         buf_sel    <= 1'b0;
         overflow   <= 1'b0;
      end else if (hblank_start) begin
         // New line always wins: abandon whatever was in flight
         buf_sel    <= ~buf_sel;
         vline      <= vcount;
         overflow   <= 1'b0;
         slot       <= '0;
         link_cnt   <= '0;
         hit_cnt    <= '0;
         pending    <= 1'b0;
         draw_valid <= 1'b0;
         vram_req   <= 1'b1;
         vram_addr  <= word_addr(MO_BASE, W_Y, '0);
         state      <= ST_RD0;
      end else begin
         case (state)
            ST_IDLE: ;
            ST_RD0, ST_RD1, ST_RD2, ST_RD3: begin
               if (pending) begin
                  pending <= 1'b0;
                  case (state)
                     ST_RD0: begin
                        ypos_q   <= vram_rdata[YPOS_W-1:0];
                        ysize_q  <= vram_rdata[YSIZE_LSB +: YSIZE_W];
                        hflip_q  <= vram_rdata[HFLIP_BIT];
                        vram_req <= 1'b1;
                        if (vm_hit) begin
                           vram_addr <= word_addr(MO_BASE, W_CODE, slot);
                           state     <= ST_RD1;
                        end else begin
                           vram_addr <= word_addr(MO_BASE, W_LINK, slot);
                           state     <= ST_RD3;
                        end
                     end
                     ST_RD1: begin
                        code_q    <= vram_rdata;
                        vram_req  <= 1'b1;
                        vram_addr <= word_addr(MO_BASE, W_X, slot);
                        state     <= ST_RD2;
                     end
                     ST_RD2: begin
                        xpos_q    <= vram_rdata[XPOS_W-1:0];
                        pal_q     <= vram_rdata[PAL_LSB +: PAL_W];
                        vram_req  <= 1'b1;
                        vram_addr <= word_addr(MO_BASE, W_LINK, slot);
                        state     <= ST_RD3;
                     end
                     default: begin
                        link_q <= vram_rdata[LINK_W-1:0];
                        state  <= ST_CHECK;
                     end
                  endcase
               end else if (vram_gnt) begin
                  vram_req <= 1'b0;
                  pending  <= 1'b1;
               end
            end
            ST_CHECK: begin
               if (vm_hit) begin
                  draw_valid <= 1'b1;
                  draw_code  <= code_q;
                  draw_row   <= vm_row;
                  draw_xpos  <= xpos_q;
                  draw_pal   <= pal_q;
                  draw_hflip <= hflip_q;
                  state      <= ST_ISSUE;
               end else begin
                  state <= ST_NEXT;
               end
            end
            ST_ISSUE: begin
               if (draw_ready) begin
                  draw_valid <= 1'b0;
                  hit_cnt    <= hit_cnt_inc;
                  if (hit_cnt_inc == HC_W'(MAX_PER_LINE)) begin
                     overflow <= 1'b1;
                     state    <= ST_IDLE;
                  end else begin
                     state <= ST_NEXT;
                  end
               end
            end
            ST_NEXT: begin
               link_cnt <= link_cnt_inc;
               slot     <= link_q;
               // Link-count cap stops circular lists from spinning forever
               if (link_q == '0 || link_cnt_inc == LC_W'(NUM_SLOTS)) begin
                  state <= ST_IDLE;
               end else begin
                  vram_req  <= 1'b1;
                  vram_addr <= word_addr(MO_BASE, W_Y, link_q);
                  state     <= ST_RD0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mo_line_scheduler.sv
// tb/tb_mo_line_scheduler.sv - directed self-checking bench for mo_line_scheduler
module tb_mo_line_scheduler;

   typedef struct packed {
      logic [15:0] code;
      logic [5:0]  row;
      logic [8:0]  xpos;
      logic [3:0]  pal;
      logic        hflip;
   } draw_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        hblank_start;
   logic [8:0]  vcount;
   logic        vram_req;
   logic [13:0] vram_addr;
   logic        vram_gnt;
   logic [15:0] vram_rdata;
   logic        draw_valid;
   logic        draw_ready;
   logic [15:0] draw_code;
   logic [5:0]  draw_row;
   logic [8:0]  draw_xpos;
   logic [3:0]  draw_pal;
   logic        draw_hflip;
   logic        buf_sel;
   logic        busy;
   logic        overflow;
   logic        overrun;

   logic [15:0] mem [0:16383];
   int          gnt_delay;
   int          wait_cnt;
   logic [13:0] gnt_addr;
   logic [13:0] addr_log [$];
   draw_t       draws [$];
   int          excl_err;
   int          unstable;
   int          stall_cnt;
   logic        hold_v;
   logic [13:0] hold_addr;
   int          n_cmp;
   int          n_bad;
   logic        exp_bs;
   logic        ovr;
   logic        found;

   always #5 clk = ~clk;

   mo_line_scheduler dut (
      .clk          (clk),
      .rst          (rst),
      .hblank_start (hblank_start),
      .vcount       (vcount),
      .vram_req     (vram_req),
      .vram_addr    (vram_addr),
      .vram_gnt     (vram_gnt),
      .vram_rdata   (vram_rdata),
      .draw_valid   (draw_valid),
      .draw_ready   (draw_ready),
      .draw_code    (draw_code),
      .draw_row     (draw_row),
      .draw_xpos    (draw_xpos),
      .draw_pal     (draw_pal),
      .draw_hflip   (draw_hflip),
      .buf_sel      (buf_sel),
      .busy         (busy),
      .overflow     (overflow),
      .overrun      (overrun)
   );

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // VRAM: grant after gnt_delay waiting cycles, data one cycle after grant
   initial begin
      vram_gnt   = 1'b0;
      vram_rdata = '0;
      wait_cnt   = 0;
      forever begin
         @(posedge clk); #1;
         if (vram_gnt) begin
            vram_rdata = mem[gnt_addr];
            vram_gnt   = 1'b0;
            wait_cnt   = 0;
         end else if (vram_req === 1'b1) begin
            if (wait_cnt >= gnt_delay) begin
               vram_gnt = 1'b1;
               gnt_addr = vram_addr;
               addr_log.push_back(vram_addr);
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Monitor: draw handshakes, req/valid exclusion, address hold while stalled
   initial begin
      excl_err  = 0;
      unstable  = 0;
      stall_cnt = 0;
      hold_v    = 1'b0;
      hold_addr = '0;
      forever begin
         @(negedge clk);
         if (vram_req === 1'b1 && draw_valid === 1'b1) excl_err++;
         if (draw_valid === 1'b1 && draw_ready === 1'b1)
            draws.push_back({draw_code, draw_row, draw_xpos, draw_pal, draw_hflip});
         if (vram_req === 1'b1 && vram_gnt === 1'b0) begin
            if (hold_v && vram_addr !== hold_addr) unstable++;
            hold_v    = 1'b1;
            hold_addr = vram_addr;
            stall_cnt++;
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   task automatic clear_mo();
      for (int i = 'h3800; i < 'h3900; i++) mem[i] = '0;
   endtask

   task automatic set_obj(input int slot, input logic [8:0] ypos, input logic [2:0] ysize,
                          input logic hflip, input logic [15:0] code, input logic [8:0] xpos,
                          input logic [3:0] pal, input logic [5:0] link);
      mem['h3800 + slot]       = {ysize, hflip, 3'b000, ypos};
      mem['h3800 + 64 + slot]  = code;
      mem['h3800 + 128 + slot] = {pal, 3'b000, xpos};
      mem['h3800 + 192 + slot] = {10'd0, link};
   endtask

   task automatic pulse_hblank(input logic [8:0] vc, output logic ovr_o);
      @(posedge clk); #1;
      vcount       = vc;
      hblank_start = 1'b1;
      @(negedge clk);
      ovr_o = overrun;
      @(posedge clk); #1;
      hblank_start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 3000) expect_eq(tag, busy, 1'b0);
   endtask

   task automatic run_line(input logic [8:0] vc, output logic ovr_o);
      draws.delete();
      addr_log.delete();
      stall_cnt = 0;
      pulse_hblank(vc, ovr_o);
      exp_bs = ~exp_bs;
      wait_idle("line_timeout");
   endtask

   initial begin
      int n;
      n_cmp        = 0;
      n_bad        = 0;
      rst          = 1'b1;
      hblank_start = 1'b0;
      vcount       = '0;
      draw_ready   = 1'b1;
      gnt_delay    = 0;
      exp_bs       = 1'b0;
      for (int i = 0; i < 16384; i++) mem[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      expect_eq("rst_busy", busy, 1'b0);
      expect_eq("rst_req", vram_req, 1'b0);
      expect_eq("rst_addr", vram_addr, 14'h0);
      expect_eq("rst_valid", draw_valid, 1'b0);
      expect_eq("rst_bufsel", buf_sel, 1'b0);
      expect_eq("rst_overflow", overflow, 1'b0);
      expect_eq("rst_overrun", overrun, 1'b0);
      rst = 1'b0;

      // Single object
      clear_mo();
      set_obj(0, 9'd100, 3'd1, 1'b0, 16'h1234, 9'd37, 4'd5, 6'd0);
      run_line(9'd105, ovr);
      expect_eq("t1_overrun", ovr, 1'b0);
      expect_eq("t1_ndraw", draws.size(), 1);
      if (draws.size() == 1) begin
         expect_eq("t1_code", draws[0].code, 16'h1234);
         expect_eq("t1_row", draws[0].row, 6'd5);
         expect_eq("t1_xpos", draws[0].xpos, 9'd37);
         expect_eq("t1_pal", draws[0].pal, 4'd5);
         expect_eq("t1_hflip", draws[0].hflip, 1'b0);
      end
      expect_eq("t1_bufsel", buf_sel, 1'b1);
      expect_eq("t1_busy", busy, 1'b0);
      expect_eq("t1_nread", addr_log.size(), 4);
      if (addr_log.size() == 4) begin
         expect_eq("t1_a0", addr_log[0], 14'h3800);
         expect_eq("t1_a1", addr_log[1], 14'h3840);
         expect_eq("t1_a2", addr_log[2], 14'h3880);
         expect_eq("t1_a3", addr_log[3], 14'h38C0);
      end
      expect_eq("t1_nostall", stall_cnt, 0);

      // Vertical wrap: hit on line 3, miss with skipped reads on line 8
      clear_mo();
      set_obj(0, 9'd510, 3'd0, 1'b1, 16'hBEEF, 9'd200, 4'hA, 6'd0);
      run_line(9'd3, ovr);
      expect_eq("wrap_ndraw", draws.size(), 1);
      if (draws.size() == 1) begin
         expect_eq("wrap_row", draws[0].row, 6'd5);
         expect_eq("wrap_code", draws[0].code, 16'hBEEF);
         expect_eq("wrap_xpos", draws[0].xpos, 9'd200);
         expect_eq("wrap_pal", draws[0].pal, 4'hA);
         expect_eq("wrap_hflip", draws[0].hflip, 1'b1);
      end
      expect_eq("wrap_bufsel", buf_sel, exp_bs);
      run_line(9'd8, ovr);
      expect_eq("miss_ndraw", draws.size(), 0);
      expect_eq("miss_nread", addr_log.size(), 2);
      if (addr_log.size() == 2) begin
         expect_eq("miss_a0", addr_log[0], 14'h3800);
         expect_eq("miss_a1", addr_log[1], 14'h38C0);
      end

      // Chain 0 -> 7 -> 3 -> 0, only slot 7 hits line 60
      clear_mo();
      set_obj(0, 9'd300, 3'd0, 1'b0, 16'h0000, 9'd0, 4'd0, 6'd7);
      set_obj(7, 9'd50, 3'd3, 1'b0, 16'h7777, 9'd511, 4'hF, 6'd3);
      set_obj(3, 9'd400, 3'd0, 1'b0, 16'h3333, 9'd1, 4'd1, 6'd0);
      run_line(9'd60, ovr);
      expect_eq("chain_ndraw", draws.size(), 1);
      if (draws.size() == 1) begin
         expect_eq("chain_code", draws[0].code, 16'h7777);
         expect_eq("chain_row", draws[0].row, 6'd10);
         expect_eq("chain_xpos", draws[0].xpos, 9'd511);
         expect_eq("chain_pal", draws[0].pal, 4'hF);
      end
      found = 1'b0;
      foreach (addr_log[i]) if (addr_log[i] == 14'h38C7) found = 1'b1;
      expect_eq("chain_link7_read", found, 1'b1);
      expect_eq("chain_nread", addr_log.size(), 8);
      if (addr_log.size() == 8) expect_eq("chain_last", addr_log[7], 14'h38C3);

      // Overflow: 20 hitting objects, 16 draws then stop
      clear_mo();
      for (int i = 0; i < 20; i++)
         set_obj(i, 9'd100, 3'd0, 1'b0, 16'h0100 + 16'(i), 9'd10, 4'd2,
                 (i == 19) ? 6'd0 : 6'(i + 1));
      run_line(9'd102, ovr);
      expect_eq("ovf_ndraw", draws.size(), 16);
      if (draws.size() == 16) expect_eq("ovf_last_code", draws[15].code, 16'h010F);
      expect_eq("ovf_flag", overflow, 1'b1);
      expect_eq("ovf_idle", busy, 1'b0);
      clear_mo();
      pulse_hblank(9'd200, ovr);
      exp_bs = ~exp_bs;
      expect_eq("ovf_cleared", overflow, 1'b0);
      wait_idle("ovf_clear_timeout");
      expect_eq("ovf_still_clear", overflow, 1'b0);

      // Overrun during ISSUE with draw_ready held low
      clear_mo();
      set_obj(0, 9'd100, 3'd1, 1'b0, 16'h1234, 9'd37, 4'd5, 6'd0);
      draw_ready = 1'b0;
      draws.delete();
      pulse_hblank(9'd105, ovr);
      exp_bs = ~exp_bs;
      n = 0;
      while (draw_valid !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      expect_eq("ovr_valid_up", draw_valid, 1'b1);
      addr_log.delete();
      pulse_hblank(9'd105, ovr);
      exp_bs = ~exp_bs;
      expect_eq("ovr_pulse", ovr, 1'b1);
      expect_eq("ovr_valid_drop", draw_valid, 1'b0);
      expect_eq("ovr_bufsel", buf_sel, exp_bs);
      expect_eq("ovr_restart_req", vram_req, 1'b1);
      expect_eq("ovr_restart_addr", vram_addr, 14'h3800);
      expect_eq("ovr_no_draw", draws.size(), 0);
      draw_ready = 1'b1;
      wait_idle("ovr_timeout");
      expect_eq("ovr_ndraw", draws.size(), 1);
      if (addr_log.size() > 0) expect_eq("ovr_first_addr", addr_log[0], 14'h3800);
      expect_eq("ovr_idle_pulse", overrun, 1'b0);

      // Delayed grant: address held steady through the wait
      gnt_delay = 5;
      unstable  = 0;
      run_line(9'd105, ovr);
      expect_eq("dly_ndraw", draws.size(), 1);
      if (draws.size() == 1) expect_eq("dly_row", draws[0].row, 6'd5);
      expect_eq("dly_stalls", stall_cnt, 20);
      expect_eq("dly_addr_stable", unstable, 0);

      // Async reset while waiting in RD2
      pulse_hblank(9'd105, ovr);
      n = 0;
      while (!(vram_req === 1'b1 && vram_addr == 14'h3880) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      expect_eq("rd2_reached", vram_addr, 14'h3880);
      #2;
      rst = 1'b1;
      #1;
      expect_eq("arst_busy", busy, 1'b0);
      expect_eq("arst_req", vram_req, 1'b0);
      expect_eq("arst_addr", vram_addr, 14'h0);
      expect_eq("arst_valid", draw_valid, 1'b0);
      expect_eq("arst_bufsel", buf_sel, 1'b0);
      @(posedge clk); #1;
      rst       = 1'b0;
      gnt_delay = 0;
      repeat (3) @(posedge clk);
      #1;
      expect_eq("arst_stays_idle", busy, 1'b0);

      expect_eq("req_valid_excl", excl_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mo_line_scheduler.md
Name: mo_line_scheduler

Overview:
- Per-scanline motion-object scheduler in front of the ping-pong MO horizontal line buffers.
- On each line it swaps the write/display buffer and walks the linked MO list in VRAM, reading through a shared VRAM request/grant port.
- For each object that vertically intersects the next line, it issues one draw command (picture code, row, X, palette, flip) to the MO graphics/line-buffer write datapath.
- It also flags overflow and overrun.

Parameters:
- MO_BASE, 14'h3800, VRAM word address of the MO table; word w of slot s is at MO_BASE + w*64 + s.
- NUM_SLOTS, 64, list length and the hard cap on the number of links walked per line.
- MAX_PER_LINE, 16, maximum draw commands per line.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- hblank_start  in  1  one-cycle pulse that starts scheduling for the next line
- vcount  in  9  number of the line being built; sampled on hblank_start
- vram_req  out  1  VRAM read request
- vram_addr  out  14  VRAM read address
- vram_gnt  in  1  grant; read data is valid on the cycle after grant
- vram_rdata  in  16  VRAM read data
- draw_valid  out  1  draw command valid
- draw_ready  in  1  draw datapath accepts the command
- draw_code  out  16  picture code (word1)
- draw_row  out  6  row within the object, 0..63
- draw_xpos  out  9  horizontal start position
- draw_pal  out  4  palette
- draw_hflip  out  1  horizontal flip
- buf_sel  out  1  buffer being written; 0 = A, 1 = B; display/clear uses ~buf_sel
- busy  out  1  list walk in progress
- overflow  out  1  sticky per line: MAX_PER_LINE was reached
- overrun  out  1  one-cycle pulse: hblank_start arrived while busy

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, slot=0, hit count=0, link count=0.
- Descriptor layout:
  - word0 = {ysize[2:0], hflip, 3'b0, ypos[8:0]}
  - word1 = code[15:0]
  - word2 = {pal[3:0], 3'b0, xpos[8:0]}
  - word3 = {10'b0, link[5:0]}
- FSM states: IDLE, RD0, RD1, RD2, RD3, CHECK, ISSUE, NEXT.
- hblank_start in any state:
  - toggles buf_sel, latches vcount, clears overflow/slot/counts, and enters RD0 on the next cycle.
  - If it arrives while busy, overrun pulses in the same cycle and the in-flight walk is abandoned.
  - If draw_valid was high, it drops the next cycle without handshake completion; this is the only case where valid drops early.
- RDn states:
  - vram_req=1 with vram_addr = MO_BASE + n*64 + slot, held stable until vram_gnt.
  - vram_rdata is captured the cycle after grant, then the FSM advances.
  - RD3 captures the link.
  - Minimum cost is 2 cycles per word.
- Skip optimisation: RD1 and RD2 are skipped (RD0 goes straight to RD3) when word0 shows no vertical hit. The link is still read.
- CHECK:
  - row = (vcount - ypos) mod 512, computed in 9 bits with wrap.
  - hit iff row < (ysize+1)*8; the limit ranges 8..64.
  - On hit: ISSUE. On miss: NEXT.
- ISSUE:
  - draw_valid=1 with all draw_* fields stable until the cycle where draw_ready=1.
  - On that cycle the hit count increments.
  - If the count reaches MAX_PER_LINE: overflow=1 and the FSM goes to IDLE. Otherwise it goes to NEXT.
- NEXT:
  - Link count increments; slot = link.
  - Go to IDLE if link==0 or link count==NUM_SLOTS (this catches circular lists). Otherwise go to RD0.
- busy=1 in every state except IDLE.
- vram_req and draw_valid are never both asserted.
- Each line walk starts at slot 0.
- Asynchronous rst mid-walk returns the FSM to IDLE immediately, with all outputs 0 and buf_sel=0.

Decomposition:
- Package mo_pkg:
  - state enum
  - descriptor field offsets/widths (YPOS_W=9, CODE_W=16, PAL_W=4, LINK_W=6)
  - word-index constants W_Y=0, W_CODE=1, W_X=2, W_LINK=3
- Sub-module mo_vmatch: purely combinational ypos/ysize/vcount → hit, row.
- FSM and register file live in mo_line_scheduler.

Test Plan:
- Single object:
  - Slot0 with ypos=100, ysize=1, code=16'h1234, x=37, pal=5, link=0; vcount=105 pulse.
  - Expected: one draw_valid with row=5, code=1234h, xpos=37, pal=5; buf_sel toggles 0→1; busy ends and returns to IDLE.
- Vertical wrap:
  - ypos=510, ysize=0, vcount=3.
  - Expected: row=5 hit. With vcount=8: miss, RD1/RD2 skipped, no draw.
- Linked chain 0→7→3→0:
  - Only slot7 hits.
  - Expected: exactly one draw, and VRAM address sequence includes MO_BASE+3*64+7.
- Overflow:
  - 20 hitting objects linked, draw_ready tied 1.
  - Expected: 16 draws, then overflow=1 and IDLE. overflow clears on the next hblank_start.
- Overrun:
  - draw_ready held 0, second hblank_start during ISSUE.
  - Expected: overrun pulse, draw_valid low the next cycle, buf_sel toggles, walk restarts at slot 0.
- Arbitration and reset:
  - vram_gnt delayed 5 cycles: vram_addr stays stable throughout.
  - rst asserted mid-RD2: all outputs 0 asynchronously.
